posit_banked_regfile: RTL
=========================

POSIT_BANKED_REGFILE -- requirements
Module: posit_banked_regfile

Interface
REQ-001 Parameter DATA_W, default 16, meaning: register width in bits.
REQ-002 Parameter REGS_PER_BANK, default 4, meaning: registers per bank; power of two, at least 2.
REQ-003 Parameter BANKS, default 4, meaning: bank count; power of two, at least 1.
REQ-004 Derived widths SHALL be AW = clog2(REGS_PER_BANK) and BW = max(1, clog2(BANKS)).
REQ-005 Port clock  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port bank  input  BW  bank select applied to both reads, the write and the clear request.
REQ-008 Ports ra1, ra2  input  AW  read addresses within the selected bank.
REQ-009 Ports wa, wd, we  input  AW / DATA_W / 1  write address, write data and write enable.
REQ-010 Port clr_req  input  1  request to zero every register of the selected bank.
REQ-011 Ports rd1, rd2  output  DATA_W  read data.
REQ-012 Ports rv1, rv2  output  1  read-valid flags: the register has been written since reset or clear.
REQ-013 Port busy  output  1  a bank clear is in progress.
REQ-014 Port wr_drop  output  1  registered one-cycle pulse: a write was discarded.

Function
REQ-015 The physical index SHALL be bank*REGS_PER_BANK + addr; storage SHALL be BANKS*REGS_PER_BANK entries, each with a valid bit.
REQ-016 Reads SHALL be combinational from the current bank, ra1/ra2 and stored state.
REQ-017 When we=1 and busy=0, wd SHALL be written at the edge, with the entry's valid bit set to 1.
REQ-018 The FSM SHALL have two states, IDLE and CLEAR; busy SHALL be 1 exactly in CLEAR.
REQ-019 IDLE to CLEAR: on clr_req=1. The bank value SHALL be latched into clr_bank and the counter clr_idx SHALL be set to 0.
REQ-020 In CLEAR, each cycle SHALL write 0 to entry clr_idx of clr_bank, clear its valid bit and increment clr_idx.
REQ-021 CLEAR to IDLE: after the write at clr_idx = REGS_PER_BANK-1. busy SHALL therefore stay high for exactly REGS_PER_BANK cycles.
REQ-022 In CLEAR, clr_req SHALL be ignored and bank changes SHALL NOT affect clr_bank.
REQ-023 Writes with we=1 while busy=1 SHALL be discarded, and wr_drop SHALL be 1 in the following cycle.
REQ-024 If clr_req=1 and we=1 in the same IDLE cycle, the write SHALL be performed and then cleared by the sweep if it targets the same bank.
REQ-025 Reads during CLEAR SHALL return the current stored values, including entries not yet swept.
REQ-026 Reading an entry whose valid bit is 0 SHALL return its stored data, which is 0 after reset or clear, with rv=0.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE, set clr_idx=0, clear all valid bits, zero all data and set wr_drop=0.
REQ-028 Reset SHALL take priority over a write, a clear request and an ongoing sweep.
REQ-029 After reset, busy=0, rd1=rd2=0 and rv1=rv2=0 for every address.

Configuration
REQ-030 Macro POSIT_RF_BYPASS_EN, when defined, SHALL enable same-cycle forwarding.
REQ-031 With POSIT_RF_BYPASS_EN, when we=1, busy=0 and wa equals ra1 or ra2, the matching rdN SHALL equal wd and rvN SHALL be 1 combinationally.
REQ-032 Without POSIT_RF_BYPASS_EN, reads SHALL return the pre-write value until the edge after the write.

Verification
REQ-033 Reset, then read all 16 entries -> every rd=0, every rv=0, busy=0.
REQ-034 bank=2, wa=1, wd=16'h4A00, we=1, then bank=2, ra1=1 next cycle -> rd1=16'h4A00, rv1=1; bank=0, ra1=1 -> rd1=0, rv1=0.
REQ-035 Fill banks 1 and 3, then clr_req with bank=1 -> busy high for 4 cycles; bank 1 reads 0 with rv=0; bank 3 unchanged.
REQ-036 we=1 in the second cycle of a CLEAR -> write discarded, wr_drop=1 in the next cycle, target entry unchanged.
REQ-037 we=1, wa=ra1=2, wd=16'h1234 with macro defined -> rd1=16'h1234 in the same cycle; without the macro -> old value, then 16'h1234 after the edge.
REQ-038 reset asserted mid-CLEAR (clr_idx=2) -> next cycle busy=0 and all entries 0 with rv=0.

Source files
------------

// File: rtl/posit_banked_regfile.sv
// Banked register file with per-entry valid bits and a sequential bank-clear sweep.
// Optional same-cycle write forwarding: define POSIT_RF_BYPASS_EN.
module posit_banked_regfile #(
    parameter int DATA_W        = 16,
    parameter int REGS_PER_BANK = 4,
    parameter int BANKS         = 4,
    localparam int AW = $clog2(REGS_PER_BANK),
    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BW-1:0]     bank,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    input  logic              clr_req,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rv1,
    output logic              rv2,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = BANKS * REGS_PER_BANK;
    localparam int IW    = $clog2(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     clr_bank_q, clr_bank_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic              wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  val_q;

    logic              wr_en, sweep;
    logic [IW-1:0]     ri1, ri2, wi, si;

    function automatic logic [IW-1:0] phys(input logic [BW-1:0] b,
                                           input logic [AW-1:0] a);
        logic [IW-1:0] bi;
        bi = (BANKS > 1) ? IW'(b) : '0;
        return bi * IW'(REGS_PER_BANK) + IW'(a);
    endfunction

    assign busy    = (state_q == CLEAR);
    assign wr_en   = we && !busy;
    assign wr_drop = wr_drop_q;
    assign ri1     = phys(bank, ra1);
    assign ri2     = phys(bank, ra2);
    assign wi      = phys(bank, wa);
    assign si      = phys(clr_bank_q, clr_idx_q);

    always_comb begin
        state_d    = state_q;
        clr_bank_d = clr_bank_q;
        clr_idx_d  = clr_idx_q;
        wr_drop_d  = we && busy;
        sweep      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_bank_d = bank;
                    clr_idx_d  = '0;
                end
            end
            CLEAR: begin
                sweep     = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(REGS_PER_BANK - 1)) begin
                    state_d   = IDLE;
                    clr_idx_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            clr_bank_q <= '0;
            clr_idx_q  <= '0;
            wr_drop_q  <= 1'b0;
            val_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            clr_bank_q <= clr_bank_d;
            clr_idx_q  <= clr_idx_d;
            wr_drop_q  <= wr_drop_d;
            // Writes only happen in IDLE and sweeps only in CLEAR: no overlap
            if (wr_en) begin
                mem_q[wi] <= wd;
                val_q[wi] <= 1'b1;
            end
            if (sweep) begin
                mem_q[si] <= '0;
                val_q[si] <= 1'b0;
            end
        end
    end

    always_comb begin
        rd1 = mem_q[ri1];
        rv1 = val_q[ri1];
        rd2 = mem_q[ri2];
        rv2 = val_q[ri2];
`ifdef POSIT_RF_BYPASS_EN
        if (wr_en && (wa == ra1)) begin
            rd1 = wd;
            rv1 = 1'b1;
        end
        if (wr_en && (wa == ra2)) begin
            rd2 = wd;
            rv2 = 1'b1;
        end
`else
`endif
    end

endmodule
